// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM encoding and defaults for the lsu_mem load/store unit.
// Optional LSU_MISALIGN_TRAP_EN build uses is_misaligned() below.
package lsu_pkg;

    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_SW   = 2'b01,
        WR_SH   = 2'b10,
        WR_SB   = 2'b11
    } wr_op_e;

    typedef enum logic [2:0] {
        RD_NONE = 3'b000,
        RD_LW   = 3'b001,
        RD_LH   = 3'b010,
        RD_LHU  = 3'b011,
        RD_LB   = 3'b100,
        RD_LBU  = 3'b101,
        RD_ILL6 = 3'b110,
        RD_ILL7 = 3'b111
    } rd_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    function automatic logic is_misaligned(input wr_op_e wr, input rd_op_e rd,
                                           input logic [1:0] off);
        logic word_op;
        logic half_op;
        word_op = (wr == WR_SW) || (rd == RD_LW);
        half_op = (wr == WR_SH) || (rd == RD_LH) || (rd == RD_LHU);
        return (word_op && (off != 2'b00)) || (half_op && off[0]);
    endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load-lane extraction: picks the byte/halfword addressed by off out of the
// bus word and sign- or zero-extends it according to the load opcode.
module lsu_ext
    import lsu_pkg::*;
(
    input  rd_op_e      rd_op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (off)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase

        // Halfword lane follows off[1] only; off[0] is a don't-care here.
        half_lane = off[1] ? word[31:16] : word[15:0];

        case (rd_op)
            RD_LW:   data = word;
            RD_LH:   data = {{16{half_lane[15]}}, half_lane};
            RD_LHU:  data = {16'h0000, half_lane};
            RD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            RD_LBU:  data = {24'h000000, byte_lane};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Single-outstanding load/store unit bridging a CPU request port to a word bus.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned word/half accesses into errors.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  mem_write,
    input  logic [2:0]  mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e           state_q;
    state_e           state_d;
    wr_op_e           wr_q;
    rd_op_e           rd_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [31:0]      ext_data;

    wr_op_e wr_in;
    rd_op_e rd_in;
    logic   accept;
    logic   misalign;
    logic   req_bad;
    logic   req_none;
    logic   timeout;
    logic   done;
    logic   done_err;
    logic   done_load;

    assign wr_in  = wr_op_e'(mem_write);
    assign rd_in  = rd_op_e'(mem_read);
    assign accept = req_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(wr_in, rd_in, addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign req_bad  = ((wr_in != WR_NONE) && (rd_in != RD_NONE)) ||
                      (rd_in == RD_ILL6) || (rd_in == RD_ILL7) || misalign;
    assign req_none = (wr_in == WR_NONE) && (rd_in == RD_NONE);
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    lsu_ext u_ext (
        .rd_op (rd_q),
        .off   (addr_q[1:0]),
        .word  (bus_rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // done marks the cycle that moves into RESP and decides what it reports.
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        done_err  = 1'b0;
        done_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_d  = S_RESP;
                        done     = 1'b1;
                        done_err = 1'b1;
                    end else if (req_none) begin
                        state_d = S_RESP;
                        done    = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    if (wr_q != WR_NONE) begin
                        state_d = S_RESP;
                        done    = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout) begin
                    state_d  = S_RESP;
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d   = S_RESP;
                    done      = 1'b1;
                    done_load = 1'b1;
                end else if (timeout) begin
                    state_d  = S_RESP;
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        bus_req   = (state_q == S_REQ);
        bus_we    = (wr_q != WR_NONE);
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = 4'b1111;
        bus_wdata = wdata_q;
        case (wr_q)
            WR_SH: begin
                bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata_q[15:0]}};
            end
            WR_SB: begin
                bus_be    = 4'b0001 << addr_q[1:0];
                bus_wdata = {4{wdata_q[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= WR_NONE;
            rd_q    <= RD_NONE;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
        end else if (accept) begin
            wr_q    <= wr_in;
            rd_q    <= rd_in;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Any state change restarts the count, so REQ and WAIT each get a full budget.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= done_load ? ext_data : 32'h0000_0000;
            err_q   <= done_err;
        end
    end

    assign rdata   = rdata_q;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed table-driven bench for lsu_mem plus hand-written timeout/reset sequences.
module tb_lsu_mem;

    typedef struct {
        logic [1:0]  wr;
        logic [2:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        bit          exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        bit          chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  mem_write = 2'b00;
    logic [2:0]  mem_read = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int   n_checks = 0;
    int   n_pass = 0;
    vec_t vecs[$];

    lsu_mem dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .addr       (addr),
        .wdata      (wdata),
        .rsp_valid  (rsp_valid),
        .rdata      (rdata),
        .rsp_err    (rsp_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic addVec(input logic [1:0] wr, input logic [2:0] rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] brd, input bit exp_bus,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input bit chk_rdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.bus_rdata = brd;
        v.exp_bus = exp_bus; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // One full transaction; the bus grants in the first REQ cycle, data returns in the first WAIT cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        checkBit({tag, ".ready"}, req_ready, 1'b1);
        req_valid = 1'b1; mem_write = v.wr; mem_read = v.rd; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0; mem_write = 2'b00; mem_read = 3'b000;
        addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
        if (v.exp_bus) begin
            checkBit({tag, ".bus_req"}, bus_req, 1'b1);
            checkOutput({tag, ".bus_addr"}, bus_addr, v.exp_addr);
            checkOutput({tag, ".bus_be"}, 32'(bus_be), 32'(v.exp_be));
            checkBit({tag, ".bus_we"}, bus_we, v.wr != 2'b00);
            if (v.wr != 2'b00) checkOutput({tag, ".bus_wdata"}, bus_wdata, v.exp_wdata);
            bus_gnt = 1'b1;
            @(negedge clk);
            bus_gnt = 1'b0;
            if (v.wr == 2'b00) begin
                checkBit({tag, ".wait_no_req"}, bus_req, 1'b0);
                bus_rvalid = 1'b1; bus_rdata = v.bus_rdata;
                @(negedge clk);
                bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_0000;
            end
        end else begin
            checkBit({tag, ".no_bus"}, bus_req, 1'b0);
        end
        checkBit({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        checkBit({tag, ".rsp_err"}, rsp_err, v.exp_err);
        if (v.chk_rdata) checkOutput({tag, ".rdata"}, rdata, v.exp_rdata);
        @(negedge clk);
        checkBit({tag, ".rsp_drop"}, rsp_valid, 1'b0);
        checkBit({tag, ".err_hold"}, rsp_err, v.exp_err);
        if (v.chk_rdata) checkOutput({tag, ".rdata_hold"}, rdata, v.exp_rdata);
    endtask

    initial begin
        bit   all_ok;
        vec_t v;

        // SB/SH/SW lane placement and replication
        addVec(2'b11, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0, 1'b0);
        addVec(2'b11, 3'b000, 32'h1001, 32'h1234_563C, 32'h0, 1, 32'h1000, 4'b0010, 32'h3C3C_3C3C, 0, 32'h0, 1'b0);
        addVec(2'b10, 3'b000, 32'h1002, 32'h1234_BEEF, 32'h0, 1, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 1'b0);
        addVec(2'b10, 3'b000, 32'h1000, 32'hFFFF_CAFE, 32'h0, 1, 32'h1000, 4'b0011, 32'hCAFE_CAFE, 0, 32'h0, 1'b0);
        addVec(2'b01, 3'b000, 32'h1004, 32'hDEAD_BEEF, 32'h0, 1, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        // Loads with sign/zero extension
        addVec(2'b00, 3'b100, 32'h2001, 32'h0, 32'h1234_80FF, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
        addVec(2'b00, 3'b101, 32'h2001, 32'h0, 32'h1234_80FF, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'h0000_0080, 1'b0);
        addVec(2'b00, 3'b010, 32'h2002, 32'h0, 32'h8001_0000, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'hFFFF_8001, 1'b0);
        addVec(2'b00, 3'b011, 32'h2002, 32'h0, 32'h8001_0000, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'h0000_8001, 1'b0);
        addVec(2'b00, 3'b001, 32'h2008, 32'h0, 32'hCAFE_F00D, 1, 32'h2008, 4'b1111, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
        addVec(2'b00, 3'b100, 32'h2000, 32'h0, 32'h0000_007F, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'h0000_007F, 1'b0);
        addVec(2'b00, 3'b101, 32'h2003, 32'h0, 32'hAB00_0000, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'h0000_00AB, 1'b0);
        addVec(2'b00, 3'b010, 32'h2000, 32'h0, 32'h0001_7FFE, 1, 32'h2000, 4'b1111, 32'h0, 1, 32'h0000_7FFE, 1'b0);
        // No-op and illegal combinations never reach the bus
        addVec(2'b00, 3'b000, 32'h7777, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0000_0000, 1'b0);
        addVec(2'b01, 3'b001, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1);
        addVec(2'b00, 3'b110, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1);
        addVec(2'b00, 3'b111, 32'h1000, 32'h0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        addVec(2'b00, 3'b001, 32'h3002, 32'h0, 32'h1357_9BDF, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1);
`else
        addVec(2'b00, 3'b001, 32'h3002, 32'h0, 32'h1357_9BDF, 1, 32'h3000, 4'b1111, 32'h0, 1, 32'h1357_9BDF, 1'b0);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        checkBit("rst.bus_req", bus_req, 1'b0);
        checkBit("rst.rsp_valid", rsp_valid, 1'b0);
        checkBit("rst.rsp_err", rsp_err, 1'b0);
        checkOutput("rst.rdata", rdata, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        checkBit("rst.ready", req_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

        // Grant never arrives: 16 REQ cycles then error, late grant/rvalid ignored
        @(negedge clk);
        req_valid = 1'b1; mem_write = 2'b00; mem_read = 3'b001; addr = 32'h4000;
        all_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = 1'b0; mem_read = 3'b000;
            if (bus_req !== 1'b1 || rsp_valid !== 1'b0) all_ok = 1'b0;
        end
        checkBit("to_req.held16", all_ok, 1'b1);
        @(negedge clk);
        checkBit("to_req.rsp_valid", rsp_valid, 1'b1);
        checkBit("to_req.rsp_err", rsp_err, 1'b1);
        checkBit("to_req.bus_req", bus_req, 1'b0);
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        checkBit("late.rsp_valid", rsp_valid, 1'b0);
        checkBit("late.ready", req_ready, 1'b1);
        @(negedge clk);
        checkBit("late.bus_req", bus_req, 1'b0);
        checkBit("late.rsp_valid2", rsp_valid, 1'b0);
        checkBit("late.err_hold", rsp_err, 1'b1);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;

        // Granted load whose data never returns: 16 WAIT cycles then error
        @(negedge clk);
        req_valid = 1'b1; mem_read = 3'b001; addr = 32'h4100;
        @(negedge clk);
        req_valid = 1'b0; mem_read = 3'b000; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        all_ok = (bus_req === 1'b0) && (rsp_valid === 1'b0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0 || rsp_valid !== 1'b0) all_ok = 1'b0;
        end
        checkBit("to_wait.held16", all_ok, 1'b1);
        @(negedge clk);
        checkBit("to_wait.rsp_valid", rsp_valid, 1'b1);
        checkBit("to_wait.rsp_err", rsp_err, 1'b1);

        // rvalid while still in REQ must not complete the load
        @(negedge clk);
        req_valid = 1'b1; mem_read = 3'b001; addr = 32'h6000;
        @(negedge clk);
        req_valid = 1'b0; mem_read = 3'b000;
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        checkBit("early_rv.still_req", bus_req, 1'b1);
        bus_rvalid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h600D_F00D;
        @(negedge clk);
        bus_rvalid = 1'b0;
        checkBit("early_rv.rsp_valid", rsp_valid, 1'b1);
        checkOutput("early_rv.rdata", rdata, 32'h600D_F00D);

        // Asynchronous reset while waiting for load data
        v = vecs[9];
        v.addr = 32'h5004; v.exp_addr = 32'h5004;
        v.bus_rdata = 32'h1122_3344; v.exp_rdata = 32'h1122_3344;
        applyStimulus(v, "pre_rst");
        @(negedge clk);
        req_valid = 1'b1; mem_read = 3'b001; addr = 32'h5000;
        @(negedge clk);
        req_valid = 1'b0; mem_read = 3'b000; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checkBit("arst.bus_req", bus_req, 1'b0);
        checkBit("arst.rsp_valid", rsp_valid, 1'b0);
        checkBit("arst.rsp_err", rsp_err, 1'b0);
        checkOutput("arst.rdata", rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hBADB_AD00;
        @(negedge clk);
        bus_rvalid = 1'b0;
        checkBit("arst.rv_ignored", rsp_valid, 1'b0);
        checkBit("arst.ready", req_ready, 1'b1);
        checkOutput("arst.rdata_kept", rdata, 32'h0);
        v.addr = 32'h5008; v.exp_addr = 32'h5008;
        v.bus_rdata = 32'h0F0F_1234; v.exp_rdata = 32'h0F0F_1234;
        applyStimulus(v, "post_rst");

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
